// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer: pending D-cache store FIFO between the LSU store path
// and the data BRAM write port. Coalesces same-word stores and flags load hazards.
module dcache_store_buffer #(
    parameter  int LINE_WORDS = 4,
    parameter  int WAY_NUM    = 2,
    parameter  int INDEX_BITS = 6,
    parameter  int DEPTH      = 4,
    localparam int WAY_BITS   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
    localparam int OFF_BITS   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
    localparam int DATA_WIDTH = 32 * LINE_WORDS * WAY_NUM,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int CNT_BITS   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [INDEX_BITS-1:0] st_index,
    input  logic [WAY_BITS-1:0]   st_way,
    input  logic [OFF_BITS-1:0]   st_offset,
    input  logic [3:0]            st_strb,
    input  logic [31:0]           st_data,
    input  logic                  ld_valid,
    input  logic [INDEX_BITS-1:0] ld_index,
    input  logic [WAY_BITS-1:0]   ld_way,
    input  logic [OFF_BITS-1:0]   ld_offset,
    output logic                  ld_hazard,
    input  logic                  bram_busy,
    output logic [INDEX_BITS-1:0] bram_waddr,
    output logic [BYTES-1:0]      bram_wen,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  empty,
    output logic [CNT_BITS-1:0]   count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int SLOTS    = LINE_WORDS * WAY_NUM;

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic [WAY_BITS-1:0]   way;
        logic [OFF_BITS-1:0]   offset;
        logic [3:0]            strb;
        logic [31:0]           data;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              mem_d [DEPTH];
    logic [PTR_BITS-1:0] head_q, head_d;
    logic [PTR_BITS-1:0] tail_q, tail_d;
    logic [PTR_BITS-1:0] last_ptr;
    logic [PTR_BITS-1:0] hz_rel;
    logic [CNT_BITS-1:0] count_q, count_d;
    entry_t              head_e;
    entry_t              last_e;
    logic                push;
    logic                pop;
    logic                merge;
    logic                alloc;

    assign head_e   = mem_q[head_q];
    assign last_ptr = tail_q - PTR_BITS'(1);
    assign last_e   = mem_q[last_ptr];

    assign st_ready = (count_q < CNT_BITS'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // A write is never issued in the reset cycle; pop only when the port is ours.
    assign pop   = !reset && (count_q != '0) && !bram_busy;
    assign push  = st_valid && st_ready;
    assign merge = push && (count_q != '0)
                && (last_e.index == st_index)
                && (last_e.way == st_way)
                && (last_e.offset == st_offset)
                && !(pop && (count_q == CNT_BITS'(1)));
    assign alloc = push && !merge;

    // FIFO next state: merge into tail, or allocate, plus head pop.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (merge) begin
            mem_d[last_ptr].strb = last_e.strb | st_strb;
            for (int b = 0; b < 4; b++) begin
                if (st_strb[b]) begin
                    mem_d[last_ptr].data[8*b +: 8] = st_data[8*b +: 8];
                end
            end
        end else if (alloc) begin
            mem_d[tail_q].index  = st_index;
            mem_d[tail_q].way    = st_way;
            mem_d[tail_q].offset = st_offset;
            mem_d[tail_q].strb   = st_strb;
            mem_d[tail_q].data   = st_data;
            tail_d = tail_q + PTR_BITS'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_BITS'(1);
        end
        case ({alloc, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; entries are cleared so the idle write bus reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Drain: head word replicated across the line, enables only at its slot.
    always_comb begin
        bram_waddr = head_e.index;
        bram_wdata = {SLOTS{head_e.data}};
        bram_wen   = '0;
        if (pop) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (int'(head_e.way) * LINE_WORDS + int'(head_e.offset) == s) begin
                    bram_wen[4*s +: 4] = head_e.strb;
                end
            end
        end
    end

    // Load hazard against every live entry, including the one draining now.
    always_comb begin
        ld_hazard = 1'b0;
        hz_rel    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hz_rel = PTR_BITS'(i) - head_q;
            if (ld_valid && (CNT_BITS'(hz_rel) < count_q)
                && (mem_q[i].index == ld_index)
                && (mem_q[i].way == ld_way)
                && (mem_q[i].offset == ld_offset)) begin
                ld_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_store_buffer.sv
// tb_dcache_store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dcache_store_buffer;

    localparam int LW    = 4;
    localparam int WN    = 2;
    localparam int IB    = 6;
    localparam int DEPTH = 4;
    localparam int WB    = 1;
    localparam int OB    = 2;
    localparam int DW    = 32 * LW * WN;
    localparam int BY    = DW / 8;
    localparam int CB    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic          st_ready;
    logic [IB-1:0] st_index;
    logic [WB-1:0] st_way;
    logic [OB-1:0] st_offset;
    logic [3:0]    st_strb;
    logic [31:0]   st_data;
    logic          ld_valid;
    logic [IB-1:0] ld_index;
    logic [WB-1:0] ld_way;
    logic [OB-1:0] ld_offset;
    logic          ld_hazard;
    logic          bram_busy;
    logic [IB-1:0] bram_waddr;
    logic [BY-1:0] bram_wen;
    logic [DW-1:0] bram_wdata;
    logic          empty;
    logic [CB-1:0] count;

    dcache_store_buffer #(
        .LINE_WORDS(LW), .WAY_NUM(WN), .INDEX_BITS(IB), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_index(st_index), .st_way(st_way), .st_offset(st_offset),
        .st_strb(st_strb), .st_data(st_data),
        .ld_valid(ld_valid), .ld_index(ld_index), .ld_way(ld_way),
        .ld_offset(ld_offset), .ld_hazard(ld_hazard),
        .bram_busy(bram_busy), .bram_waddr(bram_waddr),
        .bram_wen(bram_wen), .bram_wdata(bram_wdata),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IB-1:0] idx;
        logic [WB-1:0] way;
        logic [OB-1:0] off;
        logic [3:0]    strb;
        logic [31:0]   data;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input int idx, input int way, input int off,
                         input logic [3:0] strb, input logic [31:0] data);
        st_valid  = 1'b1;
        st_index  = IB'(idx);
        st_way    = WB'(way);
        st_offset = OB'(off);
        st_strb   = strb;
        st_data   = data;
    endtask

    // Reference model: a queue of stores, updated at each rising edge.
    always @(posedge clk) begin
        int   n;
        bit   mpop;
        bit   mpush;
        bit   mrg;
        ent_t t;
        if (reset) begin
            q.delete();
        end else begin
            n     = q.size();
            mpop  = (n > 0) && !bram_busy;
            mpush = st_valid && (n < DEPTH);
            mrg   = 1'b0;
            if (mpush && n >= 1) begin
                t   = q[n-1];
                mrg = (t.idx == st_index) && (t.way == st_way)
                   && (t.off == st_offset) && !(mpop && n == 1);
            end
            if (mrg) begin
                t.strb = t.strb | st_strb;
                for (int b = 0; b < 4; b++)
                    if (st_strb[b]) t.data[8*b +: 8] = st_data[8*b +: 8];
                q[n-1] = t;
            end
            if (mpop) void'(q.pop_front());
            if (mpush && !mrg) begin
                t.idx  = st_index;
                t.way  = st_way;
                t.off  = st_offset;
                t.strb = st_strb;
                t.data = st_data;
                q.push_back(t);
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        logic [BY-1:0] ewen;
        logic [DW-1:0] ewdata;
        bit            ehz;
        int            slot;
        if (chk_en) begin
            ewen = '0;
            if (!reset && q.size() > 0 && !bram_busy) begin
                slot = int'(q[0].way) * LW + int'(q[0].off);
                ewen = BY'(q[0].strb) << (4 * slot);
                ewdata = '0;
                for (int s = 0; s < LW * WN; s++) ewdata[32*s +: 32] = q[0].data;
                check("model_waddr", DW'(bram_waddr), DW'(q[0].idx));
                check("model_wdata", bram_wdata, ewdata);
            end
            check("model_wen", DW'(bram_wen), DW'(ewen));
            ehz = 1'b0;
            foreach (q[i])
                if (q[i].idx == ld_index && q[i].way == ld_way && q[i].off == ld_offset)
                    ehz = 1'b1;
            check("model_hazard", DW'(ld_hazard), DW'(ld_valid && ehz));
            check("model_count", DW'(count), DW'(q.size()));
            check("model_empty", DW'(empty), DW'(q.size() == 0));
            check("model_ready", DW'(st_ready), DW'(q.size() < DEPTH));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_index = '0; st_way = '0;
        st_offset = '0; st_strb = '0; st_data = '0; ld_valid = 1'b0;
        ld_index = '0; ld_way = '0; ld_offset = '0; bram_busy = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        check("rst_count", DW'(count), DW'(0));
        check("rst_empty", DW'(empty), DW'(1));
        check("rst_ready", DW'(st_ready), DW'(1));
        check("rst_wen", DW'(bram_wen), DW'(0));
        check("rst_waddr", DW'(bram_waddr), DW'(0));
        check("rst_wdata", bram_wdata, DW'(0));

        // Single store: slot 1*4+2 = 6, enables bits 25:24.
        store(5, 1, 2, 4'b0011, 32'hAABBCCDD);
        step();
        st_valid = 1'b0;
        @(negedge clk);
        check("single_waddr", DW'(bram_waddr), DW'(5));
        check("single_wen", DW'(bram_wen), DW'(32'h0300_0000));
        check("single_wdata", DW'(bram_wdata[223:192]), DW'(32'hAABBCCDD));
        step();
        check("single_count0", DW'(count), DW'(0));

        // Fill while busy, then drain in order.
        bram_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            store(10 + i, i % 2, i, 4'hF, 32'hC0DE0000 + i);
            step();
        end
        store(40, 0, 0, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("fill_count", DW'(count), DW'(4));
        check("fill_ready", DW'(st_ready), DW'(0));
        step();
        st_valid = 1'b0;
        bram_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_waddr", DW'(bram_waddr), DW'(10 + i));
            step();
        end
        check("drain_count0", DW'(count), DW'(0));

        // Coalesce two stores to the same word while busy.
        bram_busy = 1'b1;
        store(3, 0, 0, 4'b0001, 32'h11223344);
        step();
        store(3, 0, 0, 4'b0100, 32'hAABBCCDD);
        step();
        st_valid = 1'b0;
        check("merge_count", DW'(count), DW'(1));
        @(negedge clk);
        #1;
        bram_busy = 1'b0;
        #1;
        check("merge_wen", DW'(bram_wen), DW'(32'h0000_0005));
        check("merge_bytes", DW'(bram_wdata[31:0] & 32'h00FF00FF), DW'(32'h00BB0044));
        step();

        // Load hazard on index 7, way 0, offset 1.
        bram_busy = 1'b1;
        store(7, 0, 1, 4'hF, 32'h77777777);
        step();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_index = 6'd7; ld_way = 1'b0; ld_offset = 2'd1;
        @(negedge clk);
        check("hz_hit", DW'(ld_hazard), DW'(1));
        #1;
        ld_offset = 2'd2;
        #1;
        check("hz_miss_off", DW'(ld_hazard), DW'(0));
        ld_offset = 2'd1;
        bram_busy = 1'b0;
        #1;
        check("hz_draining", DW'(ld_hazard), DW'(1));
        step();
        check("hz_cleared", DW'(ld_hazard), DW'(0));
        ld_valid = 1'b0;

        // Push onto a popping single tail entry: allocate, no merge.
        bram_busy = 1'b1;
        store(9, 1, 3, 4'hF, 32'h01010101);
        step();
        bram_busy = 1'b0;
        store(9, 1, 3, 4'hF, 32'h02020202);
        step();
        st_valid = 1'b0;
        check("pp_count", DW'(count), DW'(1));
        @(negedge clk);
        check("pp_waddr", DW'(bram_waddr), DW'(9));
        check("pp_data", DW'(bram_wdata[255:224]), DW'(32'h02020202));
        step();
        check("pp_count0", DW'(count), DW'(0));

        // Reset with three entries buffered.
        bram_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            store(20 + i, 0, i, 4'hF, 32'h5A5A0000 + i);
            step();
        end
        st_valid = 1'b0;
        check("pre_rst_count", DW'(count), DW'(3));
        bram_busy = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_cycle_wen", DW'(bram_wen), DW'(0));
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_count", DW'(count), DW'(0));
        check("mid_rst_empty", DW'(empty), DW'(1));
        check("mid_rst_ready", DW'(st_ready), DW'(1));
        check("mid_rst_waddr", DW'(bram_waddr), DW'(0));
        check("mid_rst_wdata", bram_wdata, DW'(0));
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
